// File: rtl/serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : serial_add_ctrl
// Description : Bit-serial WIDTH-bit add/subtract controller that pushes the
//               operands LSB-first through one full adder with a registered
//               carry, then reports sum, carry-out and signed overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ov
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] c_last_bit = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] c_msb_bit  = CNT_W'(WIDTH - 2);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-2:0] r_sum_sh;
  logic             r_carry;
  logic             r_c_msb_in;
  logic [CNT_W-1:0] r_cnt;

  logic             w_accept;
  logic             w_run;
  logic             w_last;
  logic             w_fa_s;
  logic             w_fa_co;
  logic [WIDTH-1:0] w_sum_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_run        = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        w_run = 1'b1;
        if (r_cnt == c_last_bit) begin
          w_last       = 1'b1;
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // The single shared full adder; the sum shift register holds only the
  // WIDTH-1 bits already produced, the current bit completes the word.
  assign w_fa_s     = r_a_sh[0] ^ r_b_sh[0] ^ r_carry;
  assign w_fa_co    = (r_a_sh[0] & r_b_sh[0]) | (r_carry & (r_a_sh[0] ^ r_b_sh[0]));
  assign w_sum_next = {w_fa_s, r_sum_sh};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sh     <= '0;
      r_b_sh     <= '0;
      r_sum_sh   <= '0;
      r_carry    <= 1'b0;
      r_c_msb_in <= 1'b0;
      r_cnt      <= '0;
      s          <= '0;
      co         <= 1'b0;
      ov         <= 1'b0;
    end else if (w_accept) begin
      // Subtraction is A + ~B + 1: invert B and seed the carry with 1.
      r_a_sh   <= a;
      r_b_sh   <= sub ? ~b : b;
      r_carry  <= sub;
      r_cnt    <= '0;
      r_sum_sh <= '0;
    end else if (w_run) begin
      r_sum_sh <= w_sum_next[WIDTH-1:1];
      r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
      r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
      r_carry  <= w_fa_co;
      if (r_cnt == c_msb_bit) begin
        r_c_msb_in <= w_fa_co;
      end
      if (w_last) begin
        s  <= w_sum_next;
        co <= w_fa_co;
        ov <= w_fa_co ^ r_c_msb_in;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign busy = (r_state == ST_RUN);
  assign done = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_add_ctrl
// Description : Directed self-checking bench with a result scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_add_ctrl;

  localparam int WIDTH = 8;

  typedef struct packed {
    logic [WIDTH-1:0] s;
    logic             co;
    logic             ov;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             co;
  logic             ov;

  exp_t             sb_q[$];
  logic [WIDTH-1:0] last_s;
  int               n_checks;
  int               n_errors;

  serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .s     (s),
    .co    (co),
    .ov    (ov)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv)
    else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                                 input logic msub);
    exp_t        e;
    logic [WIDTH:0] r;
    if (msub) r = {1'b0, ma} + {1'b0, ~mb} + 1'b1;
    else      r = {1'b0, ma} + {1'b0, mb};
    e.s  = r[WIDTH-1:0];
    e.co = r[WIDTH];
    if (msub) e.ov = (ma[WIDTH-1] != mb[WIDTH-1]) && (r[WIDTH-1] != ma[WIDTH-1]);
    else      e.ov = (ma[WIDTH-1] == mb[WIDTH-1]) && (r[WIDTH-1] != ma[WIDTH-1]);
    return e;
  endfunction

  task automatic check_result(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_s"},  32'(s),  32'(e.s));
      chk({tag, "_co"}, 32'(co), 32'(e.co));
      chk({tag, "_ov"}, 32'(ov), 32'(e.ov));
      last_s = e.s;
    end
  endtask

  // One full operation: accept, WIDTH busy cycles with S held, DONE pulse, IDLE.
  task automatic do_op(input string tag, input logic [WIDTH-1:0] ta,
                       input logic [WIDTH-1:0] tbv, input logic tsub);
    @(negedge clk);
    a = ta; b = tbv; sub = tsub; start = 1'b1;
    sb_q.push_back(model(ta, tbv, tsub));
    @(posedge clk); #1;
    start = 1'b0; a = ~ta; b = ta ^ tbv; sub = ~tsub;
    for (int i = 0; i < WIDTH; i++) begin
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      chk({tag, "_done_lo"}, 32'(done), 32'd0);
      chk({tag, "_s_hold"}, 32'(s), 32'(last_s));
      if (i == 3) start = 1'b1;
      if (i == 4) start = 1'b0;
      @(posedge clk); #1;
    end
    chk({tag, "_done_hi"}, 32'(done), 32'd1);
    chk({tag, "_busy_lo"}, 32'(busy), 32'd0);
    check_result(tag);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, "_done_fall"}, 32'(done), 32'd0);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
    @(posedge clk); #1;
    chk({tag, "_start_in_done_ignored"}, 32'(busy), 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    last_s   = '0;
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_s",    32'(s),    32'd0);
    chk("rst_co",   32'(co),   32'd0);
    chk("rst_ov",   32'(ov),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op("add_5a_3c", 8'h5A, 8'h3C, 1'b0);
    do_op("add_ff_01", 8'hFF, 8'h01, 1'b0);
    do_op("add_7f_01", 8'h7F, 8'h01, 1'b0);
    do_op("sub_10_20", 8'h10, 8'h20, 1'b1);
    do_op("sub_80_01", 8'h80, 8'h01, 1'b1);
    do_op("sub_55_55", 8'h55, 8'h55, 1'b1);
    do_op("add_80_80", 8'h80, 8'h80, 1'b0);

    // START held high: each op re-accepted as soon as the FSM is back in IDLE.
    @(negedge clk);
    a = 8'h01; b = 8'h02; sub = 1'b0; start = 1'b1;
    for (int op = 0; op < 3; op++) begin
      sb_q.push_back(model(8'h01, 8'h02, 1'b0));
      @(posedge clk); #1;
      chk("held_accept", 32'(busy), 32'd1);
      a = 8'hF0; b = 8'h0F; sub = 1'b1;
      for (int i = 1; i < WIDTH; i++) begin
        @(posedge clk); #1;
        chk("held_busy", 32'(busy), 32'd1);
        if (i == WIDTH - 1) begin
          a = 8'h01; b = 8'h02; sub = 1'b0;
        end
      end
      @(posedge clk); #1;
      chk("held_done", 32'(done), 32'd1);
      check_result("held");
      @(posedge clk); #1;
      chk("held_gap", 32'(busy), 32'd0);
    end
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("held_stop_idle", 32'(busy), 32'd0);

    // Reset in the middle of an operation discards it.
    @(negedge clk);
    a = 8'h33; b = 8'h44; sub = 1'b0; start = 1'b1;
    sb_q.push_back(model(8'h33, 8'h44, 1'b0));
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_s",    32'(s),    32'd0);
    chk("midrst_co",   32'(co),   32'd0);
    chk("midrst_ov",   32'(ov),   32'd0);
    void'(sb_q.pop_front());
    last_s = '0;
    for (int i = 0; i < WIDTH + 2; i++) begin
      @(posedge clk); #1;
      chk("midrst_no_done", 32'(done), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("post_rst_no_done", 32'(done), 32'd0);
    end
    do_op("post_rst_02_03", 8'h02, 8'h03, 1'b0);

    // Held result replaced exactly on the DONE edge.
    do_op("again_5a_3c", 8'h5A, 8'h3C, 1'b0);
    do_op("hold_then_01_01", 8'h01, 8'h01, 1'b0);

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
